// File: rtl/mem_sram_responder.sv
// Memory-side responder of the full mem protocol, backed by a word-addressed
// scratchpad with fixed read latency and in-order outstanding responses.
module mem_sram_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          DEPTH           = 1024,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_req_i,
  output logic        mem_gnt_o,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_valid_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_error_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0]   LIMIT = 33'(DEPTH) << 2;
  localparam logic [CW-1:0] MAXC  = CW'(MAX_OUTSTANDING);

  logic [31:0]        mem [DEPTH];
  logic [CW-1:0]      cnt;
  logic [LATENCY-1:0] pv;
  logic [LATENCY-1:0] pe;
  logic [31:0]        pd [LATENCY];

  logic          hs;
  logic          in_range;
  logic [31:0]   offset;
  logic [31:0]   rd_word;
  logic [AW-1:0] idx;

  assign offset   = mem_addr_i - BASE_ADDR;
  assign in_range = {1'b0, offset} < LIMIT;
  assign idx      = offset[AW+1:2];

  // Credit check uses only the registered count, never this cycle's valid
  assign mem_gnt_o = rst_ni & mem_req_i & (cnt < MAXC);
  assign hs        = mem_req_i & mem_gnt_o;

  // Idle stages carry zero so rdata/error are clean whenever valid is low
  assign rd_word = (hs & in_range & ~mem_we_i) ? mem[idx] : '0;

  always_ff @(posedge clk_i) begin
    if (hs & in_range & mem_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be_i[b]) mem[idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < LATENCY; i++) pd[i] <= '0;
    end else begin
      pv[0] <= hs;
      pe[0] <= hs & ~in_range;
      pd[0] <= rd_word;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else begin
      unique case ({hs, mem_valid_o})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign mem_valid_o = pv[LATENCY-1];
  assign mem_error_o = pe[LATENCY-1];
  assign mem_rdata_o = pd[LATENCY-1];

endmodule
